pll_clkdiv_bank: RTL and testbench

- Parametrised multi-channel clock divider fed from the PLL output clock.
- Each channel produces a registered 50%-duty divided clock. Outputs are held low until the PLL reports lock, and are forced low if lock is lost.
- Adds per-channel enables, runtime-programmable ratios with glitch-free updates, clean stop on disable, and a phase-align strobe.
- Sits between SB_PLL40_CORE and the GPIO/peripheral clock consumers.

---
 rtl/pll_clkdiv_bank.sv | 143 ++++++++++++++
 tb/tb_pll_clkdiv_bank.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_clkdiv_bank.sv
// Multi-channel 50%-duty clock divider on the PLL output clock, gated by synchronised lock.
// Ratio updates are deferred to a falling edge so that a high phase never mixes two ratios.
module pll_clkdiv_bank #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pll_lock,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*DIV_W-1:0] div_in,
    input  logic                      div_load,
    input  logic                      phase_sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       running,
    output logic                      lock_ok
);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } ch_state_e;

    logic lock_meta;

    // Two-flop synchroniser for the raw PLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_ok   <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_ok   <= lock_meta;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ch_state_e        state;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] active;
        logic [DIV_W-1:0] shadow;
        logic             pend;
        logic             clk_q;
        logic             run_q;
        logic             at_end;
        logic             fall_now;
        logic             apply;

        assign at_end   = (cnt == active);
        assign fall_now = (state != ST_IDLE) && at_end && clk_q;
        assign apply    = pend && ((state == ST_IDLE) || fall_now);

        assign clk_out[i] = clk_q;
        assign running[i] = run_q;

        // Shadow ratio; a load coinciding with an apply stays pending for the next one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active <= DIV_INIT;
                shadow <= DIV_INIT;
                pend   <= 1'b0;
            end else begin
                if (apply) begin
                    active <= shadow;
                end
                if (div_load) begin
                    shadow <= div_in[i*DIV_W +: DIV_W];
                    pend   <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        // Channel FSM; lock loss overrides everything, then phase_sync, then enable
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_IDLE;
                cnt   <= '0;
                clk_q <= 1'b0;
                run_q <= 1'b0;
            end else if (!lock_ok) begin
                state <= ST_IDLE;
                cnt   <= '0;
                clk_q <= 1'b0;
                run_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt   <= '0;
                        clk_q <= 1'b0;
                        if (ch_en[i]) begin
                            state <= ST_RUN;
                            run_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (phase_sync) begin
                            cnt   <= '0;
                            clk_q <= 1'b0;
                        end else if (!ch_en[i] && (!clk_q || at_end)) begin
                            state <= ST_IDLE;
                            run_q <= 1'b0;
                            cnt   <= '0;
                            clk_q <= 1'b0;
                        end else begin
                            if (!ch_en[i]) begin
                                state <= ST_STOP;
                            end
                            if (at_end) begin
                                cnt   <= '0;
                                clk_q <= ~clk_q;
                            end else begin
                                cnt <= cnt + DIV_W'(1);
                            end
                        end
                    end
                    ST_STOP: begin
                        if (phase_sync || at_end) begin
                            state <= ST_IDLE;
                            run_q <= 1'b0;
                            cnt   <= '0;
                            clk_q <= 1'b0;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        run_q <= 1'b0;
                        cnt   <= '0;
                        clk_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_clkdiv_bank.sv
// Directed bench for pll_clkdiv_bank: lock start, ratios, glitch-free update, clean stop,
// lock loss, phase sync and asynchronous reset.
module tb_pll_clkdiv_bank;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 16;

    logic              clk;
    logic              rst_n;
    logic              pll_lock;
    logic [CH-1:0]     ch_en;
    logic [CH*DW-1:0]  div_in;
    logic              div_load;
    logic              phase_sync;
    logic [CH-1:0]     clk_out;
    logic [CH-1:0]     running;
    logic              lock_ok;

    int n_checks = 0;
    int n_pass   = 0;

    pll_clkdiv_bank #(.CHANNELS(CH), .DIV_W(DW), .DIV_RESET(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .ch_en      (ch_en),
        .div_in     (div_in),
        .div_load   (div_load),
        .phase_sync (phase_sync),
        .clk_out    (clk_out),
        .running    (running),
        .lock_ok    (lock_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference divider: value t edges after (re)start with half-period a+1
    function automatic logic model_bit(input int t, input int a);
        return ((t / (a + 1)) % 2) == 1;
    endfunction

    function automatic logic [CH-1:0] model_vec(input int t, input int a0, input int a1,
                                                input int a2, input int a3);
        return {model_bit(t, a3), model_bit(t, a2), model_bit(t, a1), model_bit(t, a0)};
    endfunction

    task automatic pulse_load(input logic [CH*DW-1:0] val);
        div_in   = val;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
    endtask

    task automatic wait_rise(input int ch, output bit found);
        logic prev;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            prev = clk_out[ch];
            step(1);
            if (clk_out[ch] && !prev) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        step(3);
        n_checks++;
        if (clk_out !== 4'b0000) $display("FAIL reset_clk_out: got %b expected 0000", clk_out);
        else n_pass++;
        n_checks++;
        if (running !== 4'b0000) $display("FAIL reset_running: got %b expected 0000", running);
        else n_pass++;
        n_checks++;
        if (lock_ok !== 1'b0) $display("FAIL reset_lock_ok: got %b expected 0", lock_ok);
        else n_pass++;
        rst_n = 1'b1;
        step(2);
        n_checks++;
        if (lock_ok !== 1'b0) $display("FAIL no_lock_lock_ok: got %b expected 0", lock_ok);
        else n_pass++;
    endtask

    task automatic test_lock_start;
        logic [CH-1:0] exp_clk [4];
        exp_clk = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};
        ch_en = 4'b0001;
        step(1);
        pll_lock = 1'b1;
        step(1);
        n_checks++;
        if (lock_ok !== 1'b0) $display("FAIL lock_edge1: got %b expected 0", lock_ok);
        else n_pass++;
        step(1);
        n_checks++;
        if (lock_ok !== 1'b1) $display("FAIL lock_edge2: got %b expected 1", lock_ok);
        else n_pass++;
        n_checks++;
        if (running !== 4'b0000) $display("FAIL lock_edge2_running: got %b expected 0000", running);
        else n_pass++;
        for (int t = 0; t < 4; t++) begin
            step(1);
            n_checks++;
            if (clk_out !== exp_clk[t])
                $display("FAIL lock_start_clk t=%0d: got %b expected %b", t, clk_out, exp_clk[t]);
            else n_pass++;
        end
        n_checks++;
        if (running !== 4'b0001) $display("FAIL lock_start_running: got %b expected 0001", running);
        else n_pass++;
    endtask

    task automatic test_ratios;
        int act [4];
        int err [4];
        int hi [4];
        int first [4];
        act = '{0, 1, 2, 3};
        err = '{0, 0, 0, 0};
        hi = '{0, 0, 0, 0};
        first = '{-1, -1, -1, -1};
        pll_lock = 1'b0;
        ch_en = 4'b0000;
        step(4);
        n_checks++;
        if (running !== 4'b0000) $display("FAIL ratios_idle: got %b expected 0000", running);
        else n_pass++;
        pulse_load({16'd3, 16'd2, 16'd1, 16'd0});
        step(2);
        pll_lock = 1'b1;
        ch_en = 4'b1111;
        step(3);
        n_checks++;
        if (running !== 4'b1111 || clk_out !== 4'b0000)
            $display("FAIL ratios_entry: got run=%b clk=%b expected run=1111 clk=0000", running, clk_out);
        else n_pass++;
        for (int t = 1; t <= 816; t++) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                if (clk_out[i] !== model_bit(t, act[i])) err[i]++;
                hi[i] += int'(clk_out[i]);
                if (first[i] < 0 && clk_out[i] === 1'b1) first[i] = t;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (err[i] != 0) $display("FAIL ratio_wave ch%0d: got %0d bad cycles expected 0", i, err[i]);
            else n_pass++;
            n_checks++;
            if (hi[i] != 408) $display("FAIL ratio_duty ch%0d: got %0d high expected 408", i, hi[i]);
            else n_pass++;
            n_checks++;
            if (first[i] != act[i] + 1)
                $display("FAIL ratio_first_rise ch%0d: got %0d expected %0d", i, first[i], act[i] + 1);
            else n_pass++;
        end
    endtask

    task automatic test_glitch_free;
        bit found;
        logic exp_seq [12];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pulse_load({16'd3, 16'd2, 16'd1, 16'd4});
        step(20);
        wait_rise(0, found);
        n_checks++;
        if (!found) $display("FAIL glitch_rise_timeout: got no rise expected a rise on ch0");
        else n_pass++;
        div_in = {16'd3, 16'd2, 16'd1, 16'd1};
        for (int j = 1; j <= 12; j++) begin
            div_load = (j == 3);
            step(1);
            n_checks++;
            if (clk_out[0] !== exp_seq[j-1])
                $display("FAIL glitch_seq +%0d: got %b expected %b", j, clk_out[0], exp_seq[j-1]);
            else n_pass++;
        end
        div_load = 1'b0;
    endtask

    task automatic test_clean_stop;
        bit found;
        pulse_load({16'd3, 16'd2, 16'd3, 16'd1});
        step(20);
        wait_rise(1, found);
        n_checks++;
        if (!found) $display("FAIL stop_rise_timeout: got no rise expected a rise on ch1");
        else n_pass++;
        ch_en = 4'b1101;
        for (int j = 1; j <= 5; j++) begin
            step(1);
            n_checks++;
            if (clk_out[1] !== (j <= 3) || running[1] !== (j <= 3))
                $display("FAIL stop_high +%0d: got clk=%b run=%b expected %b", j, clk_out[1],
                         running[1], (j <= 3));
            else n_pass++;
        end
        ch_en = 4'b1111;
        step(1);
        n_checks++;
        if (running[1] !== 1'b1 || clk_out[1] !== 1'b0)
            $display("FAIL stop_restart: got run=%b clk=%b expected run=1 clk=0", running[1], clk_out[1]);
        else n_pass++;
        ch_en = 4'b1101;
        step(1);
        n_checks++;
        if (running[1] !== 1'b0 || clk_out[1] !== 1'b0)
            $display("FAIL stop_low_phase: got run=%b clk=%b expected run=0 clk=0", running[1], clk_out[1]);
        else n_pass++;
        ch_en = 4'b1111;
    endtask

    task automatic test_lock_loss;
        logic [CH-1:0] exp;
        step(10);
        n_checks++;
        if (running !== 4'b1111) $display("FAIL loss_pre_running: got %b expected 1111", running);
        else n_pass++;
        pll_lock = 1'b0;
        step(2);
        n_checks++;
        if (running !== 4'b1111) $display("FAIL loss_edge2_running: got %b expected 1111", running);
        else n_pass++;
        step(1);
        n_checks++;
        if (clk_out !== 4'b0000 || running !== 4'b0000 || lock_ok !== 1'b0)
            $display("FAIL loss_edge3: got clk=%b run=%b lock=%b expected 0000 0000 0",
                     clk_out, running, lock_ok);
        else n_pass++;
        pll_lock = 1'b1;
        step(3);
        n_checks++;
        if (running !== 4'b1111 || clk_out !== 4'b0000)
            $display("FAIL relock_entry: got run=%b clk=%b expected 1111 0000", running, clk_out);
        else n_pass++;
        for (int t = 1; t <= 8; t++) begin
            step(1);
            exp = model_vec(t, 1, 3, 2, 3);
            n_checks++;
            if (clk_out !== exp) $display("FAIL relock_wave t=%0d: got %b expected %b", t, clk_out, exp);
            else n_pass++;
        end
    endtask

    task automatic test_phase_sync;
        logic [CH-1:0] exp;
        step(7);
        phase_sync = 1'b1;
        step(1);
        phase_sync = 1'b0;
        n_checks++;
        if (clk_out !== 4'b0000 || running !== 4'b1111)
            $display("FAIL sync_edge: got clk=%b run=%b expected 0000 1111", clk_out, running);
        else n_pass++;
        for (int t = 1; t <= 16; t++) begin
            step(1);
            exp = model_vec(t, 1, 3, 2, 3);
            n_checks++;
            if (clk_out !== exp) $display("FAIL sync_wave t=%0d: got %b expected %b", t, clk_out, exp);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        logic [CH-1:0] exp_clk [3];
        exp_clk = '{4'b0000, 4'b0001, 4'b0000};
        step(3);
        n_checks++;
        if (running !== 4'b1111) $display("FAIL areset_pre_running: got %b expected 1111", running);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (clk_out !== 4'b0000 || running !== 4'b0000 || lock_ok !== 1'b0)
            $display("FAIL areset_immediate: got clk=%b run=%b lock=%b expected 0000 0000 0",
                     clk_out, running, lock_ok);
        else n_pass++;
        ch_en = 4'b0001;
        #2;
        rst_n = 1'b1;
        step(2);
        n_checks++;
        if (lock_ok !== 1'b1) $display("FAIL areset_relock: got %b expected 1", lock_ok);
        else n_pass++;
        for (int t = 0; t < 3; t++) begin
            step(1);
            n_checks++;
            if (clk_out !== exp_clk[t])
                $display("FAIL areset_div2 t=%0d: got %b expected %b", t, clk_out, exp_clk[t]);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_lock   = 1'b0;
        ch_en      = '0;
        div_in     = '0;
        div_load   = 1'b0;
        phase_sync = 1'b0;
        test_reset();
        test_lock_start();
        test_ratios();
        test_glitch_free();
        test_clean_stop();
        test_lock_loss();
        test_phase_sync();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
